// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX write-port arbiter and its helpers.
package uart_pkg;

  localparam logic [7:0] EOL_CHAR = 8'h0A;

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_XFER = 1'b1;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      automatic int j = (int'(ptr_i) + k) % N;
      if (req_i[j]) begin
        idx_o = IW'(j);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the TX FIFO write port among NUM_REQ byte producers, round-robin with optional line lock.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int               NUM_REQ      = 4,
  parameter int               DATA_W       = 8,
  parameter int               MAX_BURST    = 16,
  parameter int               HOLD_TIMEOUT = 64,
  parameter logic [DATA_W-1:0] EOL_CHAR    = DATA_W'(uart_pkg::EOL_CHAR),
  localparam int              GW           = clog2w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic                      lock_en_i,
  input  logic                      fifo_full_i,
  output logic                      fifo_wrreq_o,
  output logic [DATA_W-1:0]         fifo_wdata_o,
  output logic [GW-1:0]             grant_id_o,
  output logic                      grant_active_o,
  output logic                      timeout_pulse_o
);

  localparam int BW = 8;
  localparam int IW = 10;

  logic [NUM_REQ-1:0][DATA_W-1:0] req_bytes;
  assign req_bytes = req_data_i;

  logic [0:0]    state_q, state_d;
  logic [GW-1:0] gid_q, gid_d;
  logic          gact_q, gact_d;
  logic          tpulse_q, tpulse_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [IW-1:0] idle_q, idle_d;

  logic [GW-1:0] pick_idx;
  logic          pick_any;

  rr_pick #(.N(NUM_REQ), .IW(GW)) u_pick (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  logic              g_vld;
  logic [DATA_W-1:0] g_data;
  logic              hs, rel, tmo;

  assign g_vld  = req_valid_i[gid_q];
  assign g_data = req_bytes[gid_q];

  always_comb begin
    req_ready_o  = '0;
    fifo_wrreq_o = 1'b0;
    fifo_wdata_o = '0;
    hs           = 1'b0;
    rel          = 1'b0;
    tmo          = 1'b0;
    state_d      = state_q;
    gid_d        = gid_q;
    gact_d       = gact_q;
    tpulse_d     = 1'b0;
    rr_ptr_d     = rr_ptr_q;
    burst_d      = burst_q;
    idle_d       = idle_q;

    if (state_q == ARB_IDLE) begin
      if (pick_any) begin
        gid_d   = pick_idx;
        gact_d  = 1'b1;
        state_d = ARB_XFER;
      end
    end else begin
      req_ready_o[gid_q] = !fifo_full_i;
      hs                 = g_vld && !fifo_full_i;
      fifo_wrreq_o       = hs;
      fifo_wdata_o       = g_data;

      if (hs) begin
        burst_d = burst_q + 1'b1;
        idle_d  = '0;
        rel     = !lock_en_i || (g_data == EOL_CHAR) ||
                  (burst_q == BW'(MAX_BURST - 1));
      end else begin
        if (idle_q != '1) idle_d = idle_q + 1'b1;
        // A full FIFO only frees a locked grant through the timeout path.
        if (lock_en_i && (idle_q == IW'(HOLD_TIMEOUT - 1))) begin
          rel = 1'b1;
          tmo = 1'b1;
        end else if (!lock_en_i && !g_vld) begin
          rel = 1'b1;
        end
      end

      if (rel) begin
        state_d  = ARB_IDLE;
        gact_d   = 1'b0;
        tpulse_d = tmo;
        rr_ptr_d = (gid_q == GW'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
        burst_d  = '0;
        idle_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      gid_q    <= '0;
      gact_q   <= 1'b0;
      tpulse_q <= 1'b0;
      rr_ptr_q <= '0;
      burst_q  <= '0;
      idle_q   <= '0;
    end else begin
      state_q  <= state_d;
      gid_q    <= gid_d;
      gact_q   <= gact_d;
      tpulse_q <= tpulse_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
      idle_q   <= idle_d;
    end
  end

  assign grant_id_o      = gid_q;
  assign grant_active_o  = gact_q;
  assign timeout_pulse_o = tpulse_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scenarios plus randomized traffic against a queue-based producer/arbiter model.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 16;
  localparam int HT = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*DW-1:0] req_data;
  logic            lock_en, fifo_full, fifo_wrreq;
  logic [DW-1:0]   fifo_wdata;
  logic [1:0]      grant_id;
  logic            grant_active, timeout_pulse;

  uart_tx_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB), .HOLD_TIMEOUT(HT), .EOL_CHAR(8'h0A)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
    .lock_en_i(lock_en), .fifo_full_i(fifo_full),
    .fifo_wrreq_o(fifo_wrreq), .fifo_wdata_o(fifo_wdata),
    .grant_id_o(grant_id), .grant_active_o(grant_active),
    .timeout_pulse_o(timeout_pulse)
  );

  always #5 clk = ~clk;

  // Producers: each requester offers the head of its byte queue unless withdrawn.
  logic [7:0] q[N][$];
  bit         hold[N];

  // Reference: who holds the port, where the rotation resumes, bytes/idle in this grant.
  bit m_act, m_pulse;
  int m_gid, m_ptr, m_burst, m_idle;

  int npass, nfail, ntot, cyc;
  int w_id[$], w_cyc[$];
  logic [7:0] w_byte[$];
  int pulses, act_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = (q[i].size() > 0) && !hold[i];
      req_data[i*DW +: DW] = (q[i].size() > 0) ? q[i][0] : 8'h00;
    end
  endtask

  task automatic step();
    logic [N-1:0] e_rdy;
    logic         e_wr, gv;
    logic [7:0]   e_wd, gb;
    bit           hs, rel, to;
    int           pick;
    drive();
    #1;
    e_rdy = '0; e_wr = 1'b0; e_wd = 8'h00; hs = 0; gv = 1'b0; gb = 8'h00;
    if (m_act) begin
      gv    = req_valid[m_gid];
      gb    = req_data[m_gid*DW +: DW];
      e_rdy = fifo_full ? '0 : (N'(1) << m_gid);
      hs    = gv && !fifo_full;
      e_wr  = hs;
      e_wd  = gb;
    end
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("fifo_wrreq", 32'(fifo_wrreq), 32'(e_wr));
    chk("fifo_wdata", 32'(fifo_wdata), 32'(e_wd));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("grant_active", 32'(grant_active), 32'(m_act));
    chk("timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
    if (fifo_wrreq === 1'b1) begin
      w_id.push_back(int'(grant_id));
      w_byte.push_back(fifo_wdata);
      w_cyc.push_back(cyc);
    end
    pulses     += int'(timeout_pulse);
    act_cycles += int'(grant_active);

    rel = 0; to = 0;
    if (!m_act) begin
      pick = -1;
      for (int k = 0; k < N; k++) begin
        automatic int j = (m_ptr + k) % N;
        if (req_valid[j] && pick < 0) pick = j;
      end
      if (pick >= 0) begin
        m_gid = pick; m_act = 1;
      end
    end else if (hs) begin
      m_burst++;
      m_idle = 0;
      if (!lock_en || gb == 8'h0A || m_burst == MB) rel = 1;
    end else begin
      if (lock_en && m_idle == HT - 1) begin rel = 1; to = 1; end
      else if (!lock_en && !gv) rel = 1;
      if (m_idle < 1023) m_idle++;
    end
    if (rel) begin
      m_act = 0; m_ptr = (m_gid + 1) % N; m_burst = 0; m_idle = 0;
    end
    m_pulse = to;

    @(posedge clk);
    #1;
    cyc++;
    if (hs) void'(q[m_gid].pop_front());
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) hold[i] = 1;
    drive();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin q[i].delete(); hold[i] = 0; end
    drive();
    m_act = 0; m_pulse = 0; m_gid = 0; m_ptr = 0; m_burst = 0; m_idle = 0;
    w_id.delete(); w_byte.delete(); w_cyc.delete();
    pulses = 0; act_cycles = 0;
    #1;
    chk("rst_grant_active", 32'(grant_active), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_timeout_pulse", 32'(timeout_pulse), 0);
    chk("rst_fifo_wrreq", 32'(fifo_wrreq), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_fifo_wdata", 32'(fifo_wdata), 0);
  endtask

  initial begin
    npass = 0; nfail = 0; ntot = 0; cyc = 0;
    reset = 1'b0; lock_en = 1'b0; fifo_full = 1'b0;
    req_valid = '0; req_data = '0;
    for (int i = 0; i < N; i++) hold[i] = 0;
    #2;

    // Unlocked 4-way contention: strict rotation, one byte every other cycle.
    do_reset();
    lock_en = 1'b0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++) q[i].push_back(8'(8'h41 + i));
    steps(16);
    chk("t1_nwrites", 32'(w_byte.size()), 8);
    for (int k = 0; k < 8 && k < w_byte.size(); k++) begin
      chk("t1_byte", 32'(w_byte[k]), 32'(8'h41 + (k % 4)));
      if (k > 0) chk("t1_gap", 32'(w_cyc[k] - w_cyc[k-1]), 2);
    end

    // Locked line "AB\n" from requester 2, then requester 0.
    do_reset();
    lock_en = 1'b1;
    q[2].push_back(8'h41); q[2].push_back(8'h42); q[2].push_back(8'h0A);
    step();
    q[0].push_back(8'h0A);
    steps(8);
    chk("t2_nwrites", 32'(w_byte.size()), 4);
    if (w_byte.size() >= 4) begin
      chk("t2_b0", 32'(w_byte[0]), 32'h41);
      chk("t2_b1", 32'(w_byte[1]), 32'h42);
      chk("t2_b2", 32'(w_byte[2]), 32'h0A);
      chk("t2_id0", 32'(w_id[0]), 2);
      chk("t2_id2", 32'(w_id[2]), 2);
      chk("t2_back2back", 32'(w_cyc[2] - w_cyc[0]), 2);
      chk("t2_next_id", 32'(w_id[3]), 0);
    end

    // Burst cap: requester 1 streams 20 bytes, others cut in after 16.
    do_reset();
    lock_en = 1'b1;
    for (int k = 0; k < 20; k++) q[1].push_back(8'(8'h61 + k));
    step();
    q[0].push_back(8'h0A);
    q[2].push_back(8'h0A);
    steps(140);
    chk("t3_nwrites", 32'(w_byte.size()), 22);
    if (w_byte.size() >= 19) begin
      for (int k = 0; k < 16; k++) begin
        chk("t3_id", 32'(w_id[k]), 1);
        chk("t3_byte", 32'(w_byte[k]), 32'(8'(8'h61 + k)));
      end
      chk("t3_after_a", 32'(w_id[16]), 2);
      chk("t3_after_b", 32'(w_id[17]), 0);
      chk("t3_regrant", 32'(w_id[18]), 1);
    end

    // Lock timeout: requester 3 granted, then withdraws.
    do_reset();
    lock_en = 1'b1;
    q[3].push_back(8'h55);
    step();
    hold[3] = 1;
    pulses = 0; act_cycles = 0;
    steps(70);
    chk("t4_pulses", 32'(pulses), 1);
    chk("t4_held_cycles", 32'(act_cycles), HT);
    chk("t4_nwrites", 32'(w_byte.size()), 0);
    hold[3] = 0;

    // FIFO full stalls a locked grant without releasing it.
    do_reset();
    lock_en = 1'b1;
    for (int k = 0; k < 5; k++) q[1].push_back(8'(8'h71 + k));
    steps(3);
    fifo_full = 1'b1;
    act_cycles = 0;
    steps(10);
    chk("t5_stall_writes", 32'(w_byte.size()), 2);
    chk("t5_held", 32'(act_cycles), 10);
    fifo_full = 1'b0;
    steps(2);
    if (w_byte.size() >= 3) chk("t5_resume_byte", 32'(w_byte[2]), 32'h73);
    else chk("t5_resume_count", 32'(w_byte.size()), 3);

    // Reset mid-lock, then a 4-way tie must go to requester 0.
    do_reset();
    lock_en = 1'b1;
    for (int k = 0; k < 8; k++) q[2].push_back(8'h20);
    steps(4);
    do_reset();
    for (int i = 0; i < N; i++) q[i].push_back(8'h0A);
    steps(3);
    if (w_id.size() >= 1) chk("t6_tie_winner", 32'(w_id[0]), 0);
    else chk("t6_tie_count", 32'(w_id.size()), 1);

    // Randomized traffic with lock toggles, FIFO backpressure and withdrawals.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(63) == 0) lock_en = ~lock_en;
      fifo_full = ($urandom_range(4) == 0);
      for (int i = 0; i < N; i++) begin
        if (q[i].size() < 3 && $urandom_range(3) == 0)
          q[i].push_back(($urandom_range(5) == 0) ? 8'h0A : 8'($urandom));
        if ($urandom_range(15) == 0) hold[i] = !hold[i];
      end
      step();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single write port of the UART TX byte FIFO among NUM_REQ independent byte producers, for example CPU-side APB writes, a debug printer and a status beacon.
- Round-robin arbitration with an optional line-lock mode: a granted requester keeps the FIFO until it sends a newline, hits a burst cap or goes silent.
- Sits between the producers and the TX FIFO write side. The FIFO read/UART sequencing is unchanged.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width of each requester's data.
- MAX_BURST, 16, maximum bytes per grant in lock mode (1..255).
- HOLD_TIMEOUT, 64, idle cycles tolerated in lock mode before forced release (2..1023).
- EOL_CHAR, 8'h0A, terminating character that releases a lock.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte available.
- req_data  in  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  per-requester byte accepted this cycle (combinational).
- lock_en  in  1  1 = line-lock mode, 0 = one byte per grant.
- fifo_full  in  1  TX FIFO full flag.
- fifo_wrreq  out  1  TX FIFO write strobe (combinational).
- fifo_wdata  out  DATA_W  TX FIFO write data (combinational mux).
- grant_id  out  clog2(NUM_REQ)  current/last granted requester (registered).
- grant_active  out  1  a grant is held (registered).
- timeout_pulse  out  1  one-cycle pulse when a lock is force-released by timeout (registered).

Behaviour:
- Reset (clk edge with reset=1) sets state=IDLE, grant_id=0, grant_active=0, timeout_pulse=0, rr_ptr=0, burst_cnt=0, idle_cnt=0.
- Combinational outputs are 0 while state=IDLE: req_ready=0, fifo_wrreq=0, fifo_wdata=0.
- States: IDLE, XFER.
- IDLE:
  - If any req_valid is set, select the first set bit searching rr_ptr, rr_ptr+1, …, wrapping modulo NUM_REQ.
  - Register the selection into grant_id, set grant_active=1, go to XFER.
  - Arbitration latency is 1 cycle from valid to grant. No transfer occurs in IDLE.
- XFER, with g = grant_id:
  - req_ready[g] = !fifo_full. All other req_ready bits = 0.
  - A handshake occurs when req_valid[g] && req_ready[g]. On handshake, fifo_wrreq=1 and fifo_wdata=req_data[g] in the same cycle; burst_cnt increments; idle_cnt clears.
  - No handshake (valid low or fifo_full) increments idle_cnt, saturating.
- Release conditions, checked each XFER cycle:
  - lock_en=0: release on the first handshake.
  - lock_en=1: release on a handshake whose byte equals EOL_CHAR, or on the handshake that makes burst_cnt reach MAX_BURST.
  - lock_en=1: also release when idle_cnt reaches HOLD_TIMEOUT-1 with no handshake that cycle. Timeout asserts timeout_pulse for the next cycle only.
  - lock_en=0: also release when req_valid[g] is low (requester withdrew), with no timeout pulse.
- On release:
  - Next cycle: state=IDLE, grant_active=0, rr_ptr=(g+1) mod NUM_REQ, burst_cnt=0, idle_cnt=0.
  - grant_id holds its last value.
- fifo_full stalls a grant but never counts toward release unless the timeout expires. A full FIFO under lock therefore eventually times out; this is intentional, so that a blocked writer yields.
- lock_en is sampled continuously. Deasserting it mid-lock releases at the next handshake or the next cycle with valid low.
- Simultaneous release and new requests: no back-to-back grant in the same cycle. There is always one IDLE cycle between grants (maximum throughput is 1 byte per 2 cycles unlocked, and close to 1 byte per cycle locked).
- Reset mid-transfer aborts the grant. A byte already strobed stays written; nothing is replayed.
- Requesters must hold req_data stable while req_valid is high and not yet accepted.

Decomposition:
- Shared package uart_pkg holds EOL_CHAR, state encodings (ARB_IDLE=1'b0, ARB_XFER=1'b1) and a function for the clog2 width used by grant_id.
- One natural sub-module, rr_pick: a combinational round-robin priority selector with inputs req vector and ptr, outputs idx and any. It is reusable for the RX-side distributor.

Test Plan:
- Reset, then with NUM_REQ=4 and lock_en=0, hold req_valid=4'b1111 with distinct bytes 0x41..0x44 → fifo_wdata order 0x41,0x42,0x43,0x44,0x41…, with fifo_wrreq high every other cycle.
- lock_en=1, requester 2 sends "AB\n" while requester 0 is valid → three consecutive fifo_wrreq cycles with 0x41,0x42,0x0A from grant_id=2, then requester 0 is granted.
- lock_en=1, requester 1 streams 20 non-EOL bytes → release after exactly 16 writes (MAX_BURST); requester 1 is regranted only after the other pending requesters.
- lock_en=1, requester 3 granted then drops valid → release after HOLD_TIMEOUT=64 idle cycles, with timeout_pulse high for exactly 1 cycle and grant_active=0 the following cycle.
- fifo_full held high for 10 cycles during a locked grant → req_ready=0 and fifo_wrreq=0 throughout, no release; on deassertion the transfer resumes with the same byte.
- reset asserted mid-lock → next cycle all outputs are at their reset values, and rr_ptr=0 is verified by requester 0 winning a 4-way tie.
